// File: rtl/mux4_rr_arbiter_if.sv
// mux4_rr_arbiter_if: requester/consumer bus of the 4:1 mux arbiter; master is the arbiter side.
interface mux4_rr_arbiter_if #(parameter int W = 8);
    logic [3:0]   req;
    logic [W-1:0] D0, D1, D2, D3;
    logic         Y_ready;
    logic [W-1:0] Y;
    logic         Y_valid;
    logic         S1, S0;
    logic [3:0]   gnt;
    logic         busy;
    modport master (input req, D0, D1, D2, D3, Y_ready, output Y, Y_valid, S1, S0, gnt, busy);
    modport slave (output req, D0, D1, D2, D3, Y_ready, input Y, Y_valid, S1, S0, gnt, busy);
endinterface

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter driving a 4:1 mux select with beat-limited tenures.
// Define MUX4_ARB_FIXED_PRIO_EN for fixed priority (requester 0 highest).
module mux4_rr_arbiter #(
    parameter int W        = 8,
    parameter int MAX_HOLD = 4
) (
    input logic              clk,
    input logic              rst_n,
    mux4_rr_arbiter_if.master bus
);
    localparam int CW = $clog2(MAX_HOLD) + 1;
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;
    logic [0:0]    state;
    logic [1:0]    sel, base, win;
    logic [CW-1:0] cnt;
    logic [3:0]    gnt;
    logic [W-1:0]  y;
    logic          found, accept, rel, y_valid;
    assign y_valid = state == GRANT && bus.req[sel];
    assign accept  = y_valid && bus.Y_ready;
    assign rel     = state == GRANT && (!bus.req[sel] || (accept && cnt == CW'(MAX_HOLD - 1)));
    assign found   = |bus.req;
`ifdef MUX4_ARB_FIXED_PRIO_EN
    assign base = 2'd0;
`else
    logic [1:0] ptr;
    // On release the search starts just past the releasing requester in the same cycle
    assign base = rel ? sel + 2'd1 : ptr;
`endif
    always_comb begin
        win = base;
        for (int i = 3; i >= 0; i--)
            if (bus.req[base + 2'(i)]) win = base + 2'(i);
    end
    assign y = sel[1] ? (sel[0] ? bus.D3 : bus.D2) : (sel[0] ? bus.D1 : bus.D0);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sel   <= 2'd0;
            gnt   <= 4'd0;
            cnt   <= '0;
`ifndef MUX4_ARB_FIXED_PRIO_EN
            ptr   <= 2'd0;
`endif
        end else if (state == IDLE || rel) begin
`ifndef MUX4_ARB_FIXED_PRIO_EN
            if (rel) ptr <= sel + 2'd1;
`endif
            state <= found ? GRANT : IDLE;
            sel   <= found ? win : sel;
            gnt   <= found ? 4'b0001 << win : 4'd0;
            cnt   <= '0;
        end else if (accept) begin
            cnt <= cnt + 1'b1;
        end
    end
    assign bus.Y       = y;
    assign bus.Y_valid = y_valid;
    assign bus.S1      = sel[1];
    assign bus.S0      = sel[0];
    assign bus.gnt     = gnt;
    assign bus.busy    = state == GRANT;
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: directed plus random stimulus checked against a tenure-level reference model.
module tb_mux4_rr_arbiter;
    localparam int W        = 8;
    localparam int MAX_HOLD = 4;
    logic clk = 1'b0;
    logic rst_n;
    int checks = 0;
    int failures = 0;
    logic [W-1:0] dv [4];
    bit m_busy;
    int m_own, m_ptr, m_cnt;

    mux4_rr_arbiter_if #(.W(W)) bus ();
    mux4_rr_arbiter #(.W(W), .MAX_HOLD(MAX_HOLD)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input int start);
        int first;
        first = -1;
        for (int k = 3; k >= 0; k--)
            if (bus.req[(start + k) % 4]) first = (start + k) % 4;
        return first;
    endfunction

    task automatic m_reset();
        m_busy = 0; m_own = 0; m_ptr = 0; m_cnt = 0;
    endtask

    task automatic model_step();
        int w;
        bit acc, done;
        if (!rst_n) begin
            m_reset();
            return;
        end
`ifdef MUX4_ARB_FIXED_PRIO_EN
        w = pick(0);
`else
        w = pick(m_ptr);
`endif
        if (!m_busy) begin
            if (w >= 0) begin m_busy = 1; m_own = w; m_cnt = 0; end
            return;
        end
        acc  = bus.req[m_own] && bus.Y_ready;
        if (acc) m_cnt++;
        done = !bus.req[m_own] || m_cnt == MAX_HOLD;
        if (done) begin
            m_ptr = (m_own + 1) % 4;
`ifdef MUX4_ARB_FIXED_PRIO_EN
            w = pick(0);
`else
            w = pick(m_ptr);
`endif
            m_cnt = 0;
            if (w >= 0) m_own = w;
            else m_busy = 0;
        end
    endtask

    task automatic check_all();
        chk("Y", 32'(bus.Y), 32'(dv[m_own]));
        chk("Y_valid", 32'(bus.Y_valid), 32'(m_busy && bus.req[m_own]));
        chk("gnt", 32'(bus.gnt), m_busy ? 32'(1 << m_own) : 32'd0);
        chk("sel", 32'({bus.S1, bus.S0}), 32'(m_own));
        chk("busy", 32'(bus.busy), 32'(m_busy));
    endtask

    task automatic apply_data();
        for (int i = 0; i < 4; i++) dv[i] = W'($urandom);
        bus.D0 = dv[0]; bus.D1 = dv[1]; bus.D2 = dv[2]; bus.D3 = dv[3];
    endtask

    task automatic cycle();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_step();
        #1;
        apply_data();
    endtask

    task automatic drive(input logic [3:0] r, input logic rdy);
        bus.req = r;
        bus.Y_ready = rdy;
    endtask

    initial begin
        m_reset();
        rst_n = 1'b0;
        drive(4'b1111, 1'b1);
        apply_data();
        repeat (2) cycle();
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_valid", 32'(bus.Y_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_sel", 32'({bus.S1, bus.S0}), 32'd0);
        rst_n = 1'b1;
        cycle();
        chk("first_gnt", 32'(bus.gnt), 32'b0001);
        // hold limit: two requesters alternate with no idle cycle
        drive(4'b0011, 1'b1);
        repeat (MAX_HOLD) cycle();
`ifdef MUX4_ARB_FIXED_PRIO_EN
        chk("hold_gnt_a", 32'(bus.gnt), 32'b0001);
`else
        chk("hold_gnt_a", 32'(bus.gnt), 32'b0010);
`endif
        repeat (MAX_HOLD) cycle();
        chk("hold_gnt_b", 32'(bus.gnt), 32'b0001);
`ifdef MUX4_ARB_FIXED_PRIO_EN
        drive(4'b1111, 1'b1);
        repeat (3 * MAX_HOLD) begin
            cycle();
            chk("fixed_gnt", 32'(bus.gnt), 32'b0001);
        end
`endif
        // early release
        drive(4'b0001, 1'b1);
        repeat (2) cycle();
        drive(4'b0000, 1'b1);
        cycle();
        chk("early_busy", 32'(bus.busy), 32'd0);
        drive(4'b1001, 1'b1);
        cycle();
`ifdef MUX4_ARB_FIXED_PRIO_EN
        chk("early_gnt", 32'(bus.gnt), 32'b0001);
`else
        chk("early_gnt", 32'(bus.gnt), 32'b1000);
`endif
        // stall on requester 2
        drive(4'b0100, 1'b0);
        cycle();
        chk("stall_gnt0", 32'(bus.gnt), 32'b0100);
        repeat (10) begin
            cycle();
            chk("stall_gnt", 32'(bus.gnt), 32'b0100);
            chk("stall_valid", 32'(bus.Y_valid), 32'd1);
        end
        drive(4'b0100, 1'b1);
        repeat (MAX_HOLD + 1) cycle();
        chk("regrant_gnt", 32'(bus.gnt), 32'b0100);
        // asynchronous reset between edges
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        m_reset();
        chk("async_gnt", 32'(bus.gnt), 32'd0);
        chk("async_busy", 32'(bus.busy), 32'd0);
        chk("async_valid", 32'(bus.Y_valid), 32'd0);
        chk("async_sel", 32'({bus.S1, bus.S0}), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        // random traffic, requests mostly held so tenures run to the limit
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) bus.req = 4'($urandom);
            bus.Y_ready = $urandom_range(0, 3) != 0;
            cycle();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
